// File: rtl/rptr_handler_fwft.sv
// rptr_handler_fwft
//   Read-side pointer handler for an asynchronous FIFO (read clock domain only).
//   It keeps the binary and Gray read pointers and a registered empty flag, and
//   drives the FIFO memory read port (registered memory with one-cycle latency).
//   A two-entry first-word-fall-through buffer hands words to the consumer over
//   a valid/ready handshake at one word per cycle.
//
//   Ports:
//     r_clk, r_rst   read clock, synchronous active-high reset
//     g_wptr_sync    Gray write pointer, already synchronised to r_clk
//     b_rptr         binary read pointer; [PTR_WIDTH-2:0] is the memory address
//     g_rptr         Gray read pointer, sent to the write-domain synchroniser
//     empty          registered empty flag
//     mem_rd_en      memory read strobe (combinational)
//     mem_rd_data    memory read data, valid one edge after mem_rd_en
//     r_valid/r_ready/r_data   consumer handshake, r_data is the buffer head
//     r_level        (RPTR_LEVEL_EN only) words still held in memory
//
//   Optional feature macro: RPTR_LEVEL_EN adds the r_level output.
module rptr_handler_fwft #(
  parameter int PTR_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [PTR_WIDTH-1:0]  g_wptr_sync,
  output logic [PTR_WIDTH-1:0]  b_rptr,
  output logic [PTR_WIDTH-1:0]  g_rptr,
  output logic                  empty,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef RPTR_LEVEL_EN
  output logic [PTR_WIDTH-1:0]  r_level,
`endif
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [PTR_WIDTH-1:0]  b_rptr_next, g_rptr_next;
  logic                  inflight;
  logic [1:0]            count, count_next;
  logic [DATA_WIDTH-1:0] head_q, tail_q, head_next, tail_next;
  logic [2:0]            occ;
  logic                  pop;

  assign pop = r_valid & r_ready;

  // Occupancy including the word the memory is returning this cycle. Fetch only
  // while that total, less the word leaving now, stays under two: the buffer
  // can then never overflow, and a pop every cycle keeps a fetch every cycle.
  assign occ       = {1'b0, count} + {2'b00, inflight};
  assign mem_rd_en = !empty && (occ < (3'd2 + {2'b00, pop}));

  assign b_rptr_next = b_rptr + {{(PTR_WIDTH-1){1'b0}}, mem_rd_en};
  assign g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;

  // Buffer: head_q is the oldest word, tail_q the second one.
  always_comb begin
    count_next = count;
    head_next  = head_q;
    tail_next  = tail_q;
    case ({inflight, pop})
      2'b10: begin
        count_next = count + 2'd1;
        if (count == 2'd0) head_next = mem_rd_data;
        else               tail_next = mem_rd_data;
      end
      2'b01: begin
        count_next = count - 2'd1;
        head_next  = tail_q;
      end
      2'b11: begin
        // Occupancy unchanged; the arriving word goes behind whatever remains.
        if (count == 2'd2) begin
          head_next = tail_q;
          tail_next = mem_rd_data;
        end else begin
          head_next = mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      b_rptr   <= '0;
      g_rptr   <= '0;
      empty    <= 1'b1;
      inflight <= 1'b0;
      count    <= 2'd0;
      r_valid  <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      b_rptr   <= b_rptr_next;
      g_rptr   <= g_rptr_next;
      // Full-width Gray compare against the post-increment pointer: the last
      // fetched word raises empty on the same edge. A stale write pointer can
      // only keep empty set longer.
      empty    <= (g_rptr_next == g_wptr_sync);
      inflight <= mem_rd_en;
      count    <= count_next;
      r_valid  <= (count_next != 2'd0);
      head_q   <= head_next;
      tail_q   <= tail_next;
    end
  end

  assign r_data = head_q;

`ifdef RPTR_LEVEL_EN
  logic [PTR_WIDTH-1:0] b_wptr;

  always_comb begin
    b_wptr = '0;
    b_wptr[PTR_WIDTH-1] = g_wptr_sync[PTR_WIDTH-1];
    for (int i = PTR_WIDTH-2; i >= 0; i--)
      b_wptr[i] = b_wptr[i+1] ^ g_wptr_sync[i];
  end

  // Words not yet read out of memory (buffered and in-flight words excluded).
  always_ff @(posedge r_clk) begin
    if (r_rst) r_level <= '0;
    else       r_level <= b_wptr - b_rptr_next;
  end
`endif

endmodule
